cpu_sequencer: RTL and testbench

//  Multi-cycle fetch/execute sequencer for the 6-bit CPU.
//  - Owns PC, instruction register (IR) and latched flag register.
//  - Fetches over a req/ack handshake; steps ALU, register file and branch logic through FETCH -> EXEC -> WB.
//  - Sits between instruction memory and the datapath (ALU, regfile, immediate mux).

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_branch_eval.sv | 23 ++
 rtl/cpu_sequencer.sv | 115 +++++++++++
 tb/tb_cpu_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 6-bit CPU control path: opcodes, sequencer states, field widths.
package cpu_pkg;

  localparam int OPC_W   = 4;
  localparam int FLAGS_W = 3;

  localparam logic [OPC_W-1:0] OPC_JMP  = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_JC   = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_JZ   = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_JN   = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
    return (opc[3] == 1'b0);
  endfunction

  function automatic logic is_jump_op(input logic [OPC_W-1:0] opc);
    return (opc[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/cpu_branch_eval.sv
// Combinational branch resolution from opcode and the latched flag register.
module cpu_branch_eval
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             c_flag,
  input  logic             z_flag,
  input  logic             s_flag,
  output logic             taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OPC_JMP: taken = 1'b1;
      OPC_JC:  taken = c_flag;
      OPC_JZ:  taken = z_flag;
      OPC_JN:  taken = s_flag;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute/writeback sequencer: owns PC, IR and flag register, drives datapath strobes.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                PC_W     = 6,
  parameter int                IMM_W    = 6,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  output logic                   IMEM_REQ,
  output logic [PC_W-1:0]        IMEM_ADDR,
  input  logic                   IMEM_ACK,
  input  logic [OPC_W+IMM_W-1:0] IMEM_DATA,
  input  logic                   CF,
  input  logic                   ZF,
  input  logic                   SF,
  output logic [1:0]             OP,
  output logic                   IM_SEL,
  output logic [IMM_W-1:0]       IMM,
  output logic                   FLAG_EN,
  output logic                   REG_EN,
  output logic                   HALTED,
  output logic [2:0]             STATE
);

  state_e                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [OPC_W+IMM_W-1:0]   ir_q, ir_d;
  logic [FLAGS_W-1:0]       flags_q, flags_d;  // {C, Z, S}

  logic [OPC_W-1:0] opc;
  logic [IMM_W-1:0] imm_field;
  logic             taken;
  logic             in_exwb;

  assign opc       = ir_q[IMM_W+OPC_W-1:IMM_W];
  assign imm_field = ir_q[IMM_W-1:0];

  cpu_branch_eval u_branch_eval (
    .opcode (opc),
    .c_flag (flags_q[2]),
    .z_flag (flags_q[1]),
    .s_flag (flags_q[0]),
    .taken  (taken)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_alu_op(opc)) begin
          flags_d = {CF, ZF, SF};
          state_d = ST_WB;
        end else if (is_jump_op(opc)) begin
          // Target equal to the current PC is fine: it simply re-fetches the same word.
          if (taken) pc_d = imm_field[PC_W-1:0];
          state_d = ST_FETCH;
        end else if (opc == OPC_HALT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALTED: begin
        if (START) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Outputs are pure functions of registered state, so they change only on clock edges.
  assign in_exwb   = (state_q == ST_EXEC) || (state_q == ST_WB);
  assign IMEM_REQ  = (state_q == ST_FETCH);
  assign IMEM_ADDR = pc_q;
  assign OP        = in_exwb ? opc[1:0] : 2'b00;
  assign IM_SEL    = in_exwb && (opc[3:2] == 2'b01);
  assign IMM       = in_exwb ? imm_field : '0;
  assign FLAG_EN   = (state_q == ST_EXEC) && is_alu_op(opc);
  assign REG_EN    = (state_q == ST_WB);
  assign HALTED    = (state_q == ST_HALTED);
  assign STATE     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, fetch handshake, ALU/jump/halt sequencing, PC wrap.
module tb_cpu_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        IMEM_REQ;
  logic [5:0]  IMEM_ADDR;
  logic        IMEM_ACK;
  logic [9:0]  IMEM_DATA;
  logic        CF, ZF, SF;
  logic [1:0]  OP;
  logic        IM_SEL;
  logic [5:0]  IMM;
  logic        FLAG_EN;
  logic        REG_EN;
  logic        HALTED;
  logic [2:0]  STATE;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_WB = 3'd3, S_HALT = 3'd4;

  cpu_sequencer #(.PC_W(6), .IMM_W(6), .RESET_PC(6'd0)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .CF(CF), .ZF(ZF), .SF(SF),
    .OP(OP), .IM_SEL(IM_SEL), .IMM(IMM), .FLAG_EN(FLAG_EN), .REG_EN(REG_EN),
    .HALTED(HALTED), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present an instruction for exactly one FETCH cycle.
  task automatic ack_with(input logic [3:0] opc, input logic [5:0] imm);
    IMEM_ACK  = 1'b1;
    IMEM_DATA = {opc, imm};
    step();
    IMEM_ACK  = 1'b0;
    IMEM_DATA = '0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; IMEM_ACK = 1'b0; IMEM_DATA = '0;
    CF = 1'b0; ZF = 1'b0; SF = 1'b0;

    // 1. Reset then START
    step(); step();
    chk("rst_state",   16'(STATE),     16'(S_IDLE));
    chk("rst_req",     16'(IMEM_REQ),  16'd0);
    chk("rst_addr",    16'(IMEM_ADDR), 16'd0);
    chk("rst_strobes", 16'({FLAG_EN, REG_EN, HALTED, IM_SEL, OP, IMM}), 16'd0);
    RST = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    chk("start_req",   16'(IMEM_REQ),  16'd1);
    chk("start_addr",  16'(IMEM_ADDR), 16'd0);

    // 2. ALU reg-imm with ACK delayed
    step(); step();
    chk("wait_state",  16'(STATE),     16'(S_FETCH));
    chk("wait_addr",   16'(IMEM_ADDR), 16'd0);
    ack_with(4'b0101, 6'd9);
    chk("exec_state",  16'(STATE),     16'(S_EXEC));
    chk("exec_op",     16'(OP),        16'b01);
    chk("exec_imsel",  16'(IM_SEL),    16'd1);
    chk("exec_imm",    16'(IMM),       16'd9);
    chk("exec_flagen", 16'(FLAG_EN),   16'd1);
    chk("exec_regen",  16'(REG_EN),    16'd0);
    step();
    chk("wb_regen",    16'(REG_EN),    16'd1);
    chk("wb_flagen",   16'(FLAG_EN),   16'd0);
    chk("wb_op",       16'(OP),        16'b01);
    chk("wb_imsel",    16'(IM_SEL),    16'd1);
    step();
    chk("refetch_addr", 16'(IMEM_ADDR), 16'd1);
    chk("refetch_req",  16'(IMEM_REQ),  16'd1);
    chk("refetch_op",   16'(OP),        16'd0);

    // 3. ALU reg-reg latching Z=1, then JZ taken, NOP, JC not taken
    ack_with(4'b0010, 6'd0);
    chk("rr_imsel",    16'(IM_SEL),    16'd0);
    chk("rr_op",       16'(OP),        16'b10);
    ZF = 1'b1;
    step();
    ZF = 1'b0;
    step();
    chk("rr_next_addr", 16'(IMEM_ADDR), 16'd2);
    ack_with(4'b1010, 6'd20);
    chk("jz_flagen",   16'(FLAG_EN),   16'd0);
    chk("jz_op",       16'(OP),        16'b10);
    step();
    chk("jz_target",   16'(IMEM_ADDR), 16'd20);
    chk("jz_state",    16'(STATE),     16'(S_FETCH));
    ack_with(4'b1100, 6'd0);
    step();
    chk("nop_addr",    16'(IMEM_ADDR), 16'd21);
    ack_with(4'b1001, 6'd40);
    CF = 1'b1;
    step();
    CF = 1'b0;
    chk("jc_fallthru", 16'(IMEM_ADDR), 16'd22);

    // 4. PC wrap through a NOP at 63
    ack_with(4'b1000, 6'd63);
    step();
    chk("jmp63_addr",  16'(IMEM_ADDR), 16'd63);
    ack_with(4'b1110, 6'd0);
    step();
    chk("wrap_addr",   16'(IMEM_ADDR), 16'd0);

    // 5. HALT at PC=5, ACK ignored while halted, restart with flags preserved
    ack_with(4'b1000, 6'd5);
    step();
    chk("jmp5_addr",   16'(IMEM_ADDR), 16'd5);
    ack_with(4'b1111, 6'd0);
    step();
    chk("halt_flag",   16'(HALTED),    16'd1);
    chk("halt_req",    16'(IMEM_REQ),  16'd0);
    chk("halt_state",  16'(STATE),     16'(S_HALT));
    ack_with(4'b1000, 6'd33);
    chk("halt_ign_ack", 16'(STATE),    16'(S_HALT));
    chk("halt_addr",   16'(IMEM_ADDR), 16'd6);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("resume_state", 16'(STATE),    16'(S_FETCH));
    chk("resume_addr", 16'(IMEM_ADDR), 16'd6);
    ack_with(4'b1010, 6'd30);
    step();
    chk("flags_kept",  16'(IMEM_ADDR), 16'd30);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("start_ign",   16'(STATE),     16'(S_FETCH));
    chk("start_ign_a", 16'(IMEM_ADDR), 16'd30);

    // 6. Reset in FETCH coinciding with ACK
    RST = 1'b1;
    ack_with(4'b0101, 6'd5);
    RST = 1'b0;
    chk("rstack_state", 16'(STATE),    16'(S_IDLE));
    chk("rstack_pc",   16'(IMEM_ADDR), 16'd0);
    chk("rstack_ir",   16'(dut.ir_q),  16'd0);
    START = 1'b1;
    step();
    START = 1'b0;
    ack_with(4'b1010, 6'd12);
    ZF = 1'b1;
    step();
    ZF = 1'b0;
    chk("rst_flags_clr", 16'(IMEM_ADDR), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
